// File: rtl/aes_block_sequencer_if.sv
// Streamer bus between the AES block sequencer and its source/sink streamers.
// master: sequencer side (drives requests, addresses, sink strobe).
// slave : streamer side (drives ready/done handshakes).
interface aes_block_sequencer_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = 4
);
  logic                  src_req_o;
  logic [ADDR_W-1:0]     src_addr_o;
  logic                  src_ready_i;
  logic                  src_done_i;
  logic                  snk_req_o;
  logic [ADDR_W-1:0]     snk_addr_o;
  logic [WORD_BYTES-1:0] snk_strb_o;
  logic                  snk_ready_i;
  logic                  snk_done_i;

  modport master (
    output src_req_o, src_addr_o, snk_req_o, snk_addr_o, snk_strb_o,
    input  src_ready_i, src_done_i, snk_ready_i, snk_done_i
  );

  modport slave (
    input  src_req_o, src_addr_o, snk_req_o, snk_addr_o, snk_strb_o,
    output src_ready_i, src_done_i, snk_ready_i, snk_done_i
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// AES HWPE block sequencer: splits a byte-length job into AES blocks, and per
// block fetches words from the source streamer, runs the engine and writes the
// result through the sink streamer. The final partial block uses a reduced
// word count and a partial byte strobe on the very last word.
// Ports:
//   clk, reset (sync, active-high), clear (sync soft clear)
//   start_i, byte_length_i, in_base_i, out_base_i : job command
//   busy_o, done_o, blocks_done_o                 : job status
//   strm (master)                                 : source/sink streamer bus
//   word_idx_o, eng_load_o, eng_clear_o, eng_start_o, eng_done_i,
//   eng_nwords_o                                  : engine control
module aes_block_sequencer #(
  parameter int unsigned WORD_BYTES      = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned WIDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1,
  localparam int unsigned NW_W   = $clog2(WORDS_PER_BLOCK) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start_i,
  input  logic [31:0]        byte_length_i,
  input  logic [ADDR_W-1:0]  in_base_i,
  input  logic [ADDR_W-1:0]  out_base_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   blocks_done_o,
  aes_block_sequencer_if.master strm,
  output logic [WIDX_W-1:0]  word_idx_o,
  output logic               eng_load_o,
  output logic               eng_clear_o,
  output logic               eng_start_o,
  input  logic               eng_done_i,
  output logic [NW_W-1:0]    eng_nwords_o
);
  localparam int unsigned BLOCK_BYTES = WORD_BYTES * WORDS_PER_BLOCK;

  typedef enum logic [3:0] {
    IDLE, LOAD, RD_REQ, RD_WAIT, ENG_START, ENG_WAIT,
    WR_REQ, WR_WAIT, BLK_NEXT, DONE
  } state_t;

  state_t              state;
  logic [31:0]         len_q;
  logic [31:0]         rem_q;      // bytes left from the current block onward
  logic [ADDR_W-1:0]   in_base_q;
  logic [ADDR_W-1:0]   out_base_q;
  logic [ADDR_W-1:0]   blk_off_q;  // blk * BLOCK_BYTES, kept incrementally
  logic [WIDX_W-1:0]   word_q;
  logic [CNT_W-1:0]    blk_cnt_q;

  logic [NW_W-1:0]       nw;
  logic                  last_word;
  logic                  last_blk;
  logic [31:0]           tail;
  logic [ADDR_W-1:0]     word_off;
  logic [WORD_BYTES-1:0] strb;

  always_comb begin
    if (rem_q >= 32'(BLOCK_BYTES)) nw = NW_W'(WORDS_PER_BLOCK);
    else                           nw = NW_W'((rem_q + 32'(WORD_BYTES - 1)) / 32'(WORD_BYTES));
  end

  assign last_word = (NW_W'(word_q) + NW_W'(1)) == nw;
  // rem_q is nonzero in every active block, so this matches blk+1 == ceil(len/BLOCK_BYTES)
  assign last_blk  = rem_q <= 32'(BLOCK_BYTES);
  assign tail      = len_q & 32'(WORD_BYTES - 1);
  assign word_off  = ADDR_W'(word_q) * ADDR_W'(WORD_BYTES);

  always_comb begin
    strb = '1;
    if ((state == WR_REQ || state == WR_WAIT) && last_blk && last_word && tail != '0) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) strb[i] = (32'(i) < tail);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      blk_off_q  <= '0;
      word_q     <= '0;
      blk_cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          len_q      <= byte_length_i;
          rem_q      <= byte_length_i;
          in_base_q  <= in_base_i;
          out_base_q <= out_base_i;
          blk_off_q  <= '0;
          word_q     <= '0;
          blk_cnt_q  <= '0;
          state      <= LOAD;
        end
        LOAD:    state <= (len_q == '0) ? DONE : RD_REQ;
        RD_REQ:  if (strm.src_ready_i) state <= RD_WAIT;
        RD_WAIT: if (strm.src_done_i) begin
          if (last_word) begin
            word_q <= '0;
            state  <= ENG_START;
          end else begin
            word_q <= word_q + WIDX_W'(1);
            state  <= RD_REQ;
          end
        end
        ENG_START: state <= ENG_WAIT;
        ENG_WAIT:  if (eng_done_i) state <= WR_REQ;
        WR_REQ:    if (strm.snk_ready_i) state <= WR_WAIT;
        WR_WAIT: if (strm.snk_done_i) begin
          if (last_word) begin
            word_q <= '0;
            state  <= BLK_NEXT;
          end else begin
            word_q <= word_q + WIDX_W'(1);
            state  <= WR_REQ;
          end
        end
        BLK_NEXT: begin
          blk_cnt_q <= blk_cnt_q + CNT_W'(1);
          blk_off_q <= blk_off_q + ADDR_W'(BLOCK_BYTES);
          rem_q     <= rem_q - 32'(BLOCK_BYTES);
          state     <= last_blk ? DONE : RD_REQ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o          = state != IDLE;
  assign done_o          = state == DONE;
  assign blocks_done_o   = blk_cnt_q;
  assign word_idx_o      = word_q;
  assign eng_nwords_o    = nw;
  assign eng_load_o      = (state == RD_WAIT) && strm.src_done_i;
  assign eng_clear_o     = (state == IDLE) || (state == BLK_NEXT);
  assign eng_start_o     = state == ENG_START;
  assign strm.src_req_o  = state == RD_REQ;
  assign strm.snk_req_o  = state == WR_REQ;
  assign strm.src_addr_o = in_base_q + blk_off_q + word_off;
  assign strm.snk_addr_o = out_base_q + blk_off_q + word_off;
  assign strm.snk_strb_o = strb;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer (WORD_BYTES=4, WORDS_PER_BLOCK=4).
// Streamer and engine responders with programmable latency; expected reads,
// writes and per-block word counts are queued per job and popped on handshakes.
module tb_aes_block_sequencer;
  logic        clk = 1'b0;
  logic        reset, clear, start_i;
  logic [31:0] byte_length_i, in_base_i, out_base_i;
  logic        busy_o, done_o;
  logic [15:0] blocks_done_o;
  logic [1:0]  word_idx_o;
  logic        eng_load_o, eng_clear_o, eng_start_o, eng_done_i;
  logic [2:0]  eng_nwords_o;

  aes_block_sequencer_if #(.ADDR_W(32), .WORD_BYTES(4)) strm ();

  aes_block_sequencer #(
    .WORD_BYTES(4), .WORDS_PER_BLOCK(4), .ADDR_W(32), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i),
    .byte_length_i(byte_length_i), .in_base_i(in_base_i), .out_base_i(out_base_i),
    .busy_o(busy_o), .done_o(done_o), .blocks_done_o(blocks_done_o),
    .strm(strm),
    .word_idx_o(word_idx_o), .eng_load_o(eng_load_o), .eng_clear_o(eng_clear_o),
    .eng_start_o(eng_start_o), .eng_done_i(eng_done_i), .eng_nwords_o(eng_nwords_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rd_q[$];
  logic [31:0] wr_addr_q[$];
  logic [3:0]  wr_strb_q[$];
  int          nw_q[$];

  int done_cnt = 0, load_cnt = 0, start_cnt = 0, req_cyc = 0;
  int src_delay = 0, snk_delay = 0, eng_delay = 1;

  // Source streamer: ready after src_delay request cycles, done one cycle later.
  initial begin
    int cnt = 0;
    bit pend = 0;
    strm.src_ready_i = 0; strm.src_done_i = 0;
    forever begin
      @(posedge clk); #1;
      strm.src_ready_i = 0; strm.src_done_i = 0;
      if (pend) begin strm.src_done_i = 1; pend = 0; end
      else if (strm.src_req_o) begin
        if (cnt >= src_delay) begin strm.src_ready_i = 1; pend = 1; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    bit pend = 0;
    strm.snk_ready_i = 0; strm.snk_done_i = 0;
    forever begin
      @(posedge clk); #1;
      strm.snk_ready_i = 0; strm.snk_done_i = 0;
      if (pend) begin strm.snk_done_i = 1; pend = 0; end
      else if (strm.snk_req_o) begin
        if (cnt >= snk_delay) begin strm.snk_ready_i = 1; pend = 1; cnt = 0; end
        else cnt++;
      end
    end
  end

  // Engine: eng_done_i pulses eng_delay cycles after eng_start_o.
  initial begin
    int cnt = 0;
    eng_done_i = 0;
    forever begin
      @(posedge clk); #1;
      eng_done_i = 0;
      if (cnt > 0) begin cnt--; if (cnt == 0) eng_done_i = 1; end
      else if (eng_start_o) cnt = (eng_delay < 1) ? 1 : eng_delay;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  bit          src_stall = 0, snk_stall = 0;
  logic [31:0] src_stall_addr, snk_stall_addr;
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (strm.src_req_o || strm.snk_req_o) req_cyc++;
      if (eng_load_o) load_cnt++;
      if (done_o) done_cnt++;
      if (src_stall) begin
        n_vec++;
        if (!strm.src_req_o || strm.src_addr_o !== src_stall_addr) begin
          n_err++;
          $display("FAIL src_stall_hold: req=%0b addr=%h required req=1 addr=%h",
                   strm.src_req_o, strm.src_addr_o, src_stall_addr);
        end
      end
      src_stall = strm.src_req_o && !strm.src_ready_i;
      src_stall_addr = strm.src_addr_o;
      if (snk_stall) begin
        n_vec++;
        if (!strm.snk_req_o || strm.snk_addr_o !== snk_stall_addr) begin
          n_err++;
          $display("FAIL snk_stall_hold: req=%0b addr=%h required req=1 addr=%h",
                   strm.snk_req_o, strm.snk_addr_o, snk_stall_addr);
        end
      end
      snk_stall = strm.snk_req_o && !strm.snk_ready_i;
      snk_stall_addr = strm.snk_addr_o;
      if (strm.src_req_o && strm.src_ready_i) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL src_unexpected: addr=%h required no read", strm.src_addr_o);
        end else begin
          logic [31:0] e;
          e = rd_q.pop_front();
          if (strm.src_addr_o !== e) begin
            n_err++;
            $display("FAIL src_addr: got %h required %h", strm.src_addr_o, e);
          end
        end
      end
      if (strm.snk_req_o && strm.snk_ready_i) begin
        n_vec++;
        if (wr_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL snk_unexpected: addr=%h required no write", strm.snk_addr_o);
        end else begin
          logic [31:0] ea;
          logic [3:0]  es;
          ea = wr_addr_q.pop_front();
          es = wr_strb_q.pop_front();
          if (strm.snk_addr_o !== ea || strm.snk_strb_o !== es) begin
            n_err++;
            $display("FAIL snk_write: got addr=%h strb=%h required addr=%h strb=%h",
                     strm.snk_addr_o, strm.snk_strb_o, ea, es);
          end
        end
      end
      if (eng_start_o) begin
        start_cnt++;
        n_vec++;
        if (nw_q.size() == 0) begin
          n_err++;
          $display("FAIL eng_start_unexpected: nwords=%0d required no start", eng_nwords_o);
        end else begin
          int e;
          e = nw_q.pop_front();
          if (int'(eng_nwords_o) !== e) begin
            n_err++;
            $display("FAIL eng_nwords: got %0d required %0d", eng_nwords_o, e);
          end
        end
      end
    end
  end

  task automatic push_job(input int unsigned len, input logic [31:0] inb, input logic [31:0] outb,
                          output int unsigned blocks, output int unsigned words);
    blocks = (len + 15) / 16;
    words  = 0;
    for (int unsigned b = 0; b < blocks; b++) begin
      int unsigned rem, nw;
      rem = len - b * 16;
      nw  = (rem >= 16) ? 4 : (rem + 3) / 4;
      nw_q.push_back(int'(nw));
      for (int unsigned w = 0; w < nw; w++) begin
        logic [3:0] s;
        s = 4'hF;
        if (b == blocks - 1 && w == nw - 1 && (len % 4) != 0) s = 4'((1 << (len % 4)) - 1);
        rd_q.push_back(inb + b * 16 + w * 4);
        wr_addr_q.push_back(outb + b * 16 + w * 4);
        wr_strb_q.push_back(s);
        words++;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] len, input logic [31:0] inb, input logic [31:0] outb);
    @(posedge clk); #1;
    byte_length_i = len; in_base_i = inb; out_base_i = outb; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic run_job(input string name, input int unsigned len,
                         input logic [31:0] inb, input logic [31:0] outb, input bit poke_busy);
    int unsigned blocks, words;
    int d0, l0;
    push_job(len, inb, outb, blocks, words);
    d0 = done_cnt; l0 = load_cnt;
    pulse_start(len, inb, outb);
    if (poke_busy) begin
      repeat (6) @(posedge clk);
      #1;
      byte_length_i = 32'd16; in_base_i = 32'h9000; out_base_i = 32'hA000; start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
    end
    for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d required 1", name, done_cnt - d0);
    end
    n_vec++;
    if (int'(blocks_done_o) != int'(blocks)) begin
      n_err++;
      $display("FAIL %s blocks_done: got %0d required %0d", name, blocks_done_o, blocks);
    end
    n_vec++;
    if (load_cnt - l0 != int'(words)) begin
      n_err++;
      $display("FAIL %s eng_loads: got %0d required %0d", name, load_cnt - l0, words);
    end
    n_vec++;
    if (rd_q.size() + wr_addr_q.size() + nw_q.size() != 0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s leftover: rd=%0d wr=%0d nw=%0d busy=%0b required 0 0 0 0",
               name, rd_q.size(), wr_addr_q.size(), nw_q.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; start_i = 0;
    byte_length_i = '0; in_base_i = '0; out_base_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    n_vec++;
    if ({busy_o, done_o, strm.src_req_o, strm.snk_req_o, eng_start_o, eng_load_o} !== 6'b0 ||
        blocks_done_o !== 16'd0 || strm.snk_strb_o !== 4'hF || eng_clear_o !== 1'b1 ||
        word_idx_o !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%0b done=%0b blk=%0d strb=%h clr=%0b required 0 0 0 f 1",
               busy_o, done_o, blocks_done_o, strm.snk_strb_o, eng_clear_o);
    end
  endtask

  task automatic test_zero_length();
    int r0, d0;
    r0 = req_cyc; d0 = done_cnt;
    @(posedge clk); #1;
    byte_length_i = 0; in_base_i = 32'h1000; out_base_i = 32'h2000; start_i = 1;
    @(negedge clk);
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL len0_load: done=%0b busy=%0b required 0 1", done_o, busy_o);
    end
    @(negedge clk);
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL len0_done_latency: done=%0b required 1", done_o);
    end
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (req_cyc != r0 || done_cnt - d0 != 1 || blocks_done_o !== 16'd0) begin
      n_err++;
      $display("FAIL len0_quiet: req_cycles=%0d dones=%0d blk=%0d required 0 1 0",
               req_cyc - r0, done_cnt - d0, blocks_done_o);
    end
  endtask

  task automatic test_clear_midjob();
    int unsigned blocks, words;
    int s0, d0;
    eng_delay = 20;
    push_job(40, 32'h1000, 32'h2000, blocks, words);
    s0 = start_cnt; d0 = done_cnt;
    pulse_start(32'd40, 32'h1000, 32'h2000);
    for (int c = 0; c < 2000 && start_cnt < s0 + 2; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (blocks_done_o !== 16'd1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL clear_precondition: blk=%0d busy=%0b required 1 1", blocks_done_o, busy_o);
    end
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    #1;
    n_vec++;
    if (busy_o !== 1'b0 || blocks_done_o !== 16'd0 || eng_clear_o !== 1'b1) begin
      n_err++;
      $display("FAIL clear_abort: busy=%0b blk=%0d clr=%0b required 0 0 1",
               busy_o, blocks_done_o, eng_clear_o);
    end
    rd_q.delete(); wr_addr_q.delete(); wr_strb_q.delete(); nw_q.delete();
    repeat (40) @(posedge clk);
    #2;
    n_vec++;
    if (done_cnt != d0) begin
      n_err++;
      $display("FAIL clear_no_done: dones=%0d required 0", done_cnt - d0);
    end
    eng_delay = 1;
    run_job("restart16", 16, 32'h1000, 32'h2000, 0);
  endtask

  initial begin
    test_reset();
    run_job("len16", 16, 32'h1000, 32'h2000, 0);
    run_job("len40", 40, 32'h1000, 32'h2000, 0);
    run_job("len37", 37, 32'h1000, 32'h2000, 0);
    test_zero_length();
    src_delay = 5; snk_delay = 5; eng_delay = 20;
    run_job("stall40", 40, 32'h1000, 32'h2000, 1);
    run_job("wrap21", 21, 32'hFFFF_FFF8, 32'h0000_3000, 0);
    src_delay = 0; snk_delay = 0; eng_delay = 1;
    test_clear_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
